// File: rtl/fault_mem_pkg.sv
// -----------------------------------------------------------------------------
// fault_mem_pkg
// Shared definitions for the configurable fault-injecting memory model:
// fault-class encodings, the width of the fault-hit counter and a saturating
// increment helper.
// -----------------------------------------------------------------------------
package fault_mem_pkg;

    // Fault-class encodings carried on cfg_mode; 5..7 decode as no fault.
    localparam logic [2:0] FM_NONE = 3'd0;
    localparam logic [2:0] FM_SAF  = 3'd1;
    localparam logic [2:0] FM_TF   = 3'd2;
    localparam logic [2:0] FM_CFID = 3'd3;
    localparam logic [2:0] FM_NPSF = 3'd4;

    localparam int              HIT_W   = 16;
    localparam logic [HIT_W-1:0] HIT_MAX = '1;

    function automatic logic [HIT_W-1:0] sat_inc(input logic [HIT_W-1:0] v);
        return (v == HIT_MAX) ? v : v + HIT_W'(1);
    endfunction

endpackage

// File: rtl/fault_mem_inject.sv
// -----------------------------------------------------------------------------
// fault_mem_inject
// Combinational fault injector. Given the access in the array stage and the
// active fault configuration, produces the word to commit (write) or return
// (read), an optional CFID side-write into the victim word, and a hit flag
// that is set when the faulted outcome differs from the fault-free one.
//
// Ports
//   mode_i      active fault class (FM_*), unknown encodings act as none
//   bit_i       victim / aggressor bit index
//   val_i       stuck / blocked-target / forced value
//   wr_i        1 = access is a write, 0 = read
//   vic_sel_i   access targets the (in-range) victim word
//   aggr_sel_i  access targets the aggressor and CFID is physically possible
//   ref_bit_i   fault-free value of the victim bit (for SAF reads)
//   nbr_hi_i    victim+1 bit, 0 when outside the array
//   nbr_lo_i    victim-1 bit, 0 when outside the array
//   old_word_i  current content of the accessed word
//   new_word_i  write data
//   vic_word_i  current content of the victim word
//   word_o      word to commit (write) or to return (read)
//   vic_we_o    CFID side-write enable into the victim word
//   vic_word_o  victim word with the forced bit applied
//   hit_o       fault changed a stored or returned value
// -----------------------------------------------------------------------------
module fault_mem_inject
    import fault_mem_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int BIT_W      = 3
) (
    input  logic [2:0]            mode_i,
    input  logic [BIT_W-1:0]      bit_i,
    input  logic                  val_i,
    input  logic                  wr_i,
    input  logic                  vic_sel_i,
    input  logic                  aggr_sel_i,
    input  logic                  ref_bit_i,
    input  logic                  nbr_hi_i,
    input  logic                  nbr_lo_i,
    input  logic [DATA_WIDTH-1:0] old_word_i,
    input  logic [DATA_WIDTH-1:0] new_word_i,
    input  logic [DATA_WIDTH-1:0] vic_word_i,
    output logic [DATA_WIDTH-1:0] word_o,
    output logic                  vic_we_o,
    output logic [DATA_WIDTH-1:0] vic_word_o,
    output logic                  hit_o
);

    always_comb begin
        word_o            = wr_i ? new_word_i : old_word_i;
        vic_we_o          = 1'b0;
        vic_word_o        = vic_word_i;
        vic_word_o[bit_i] = val_i;
        hit_o             = 1'b0;

        case (mode_i)
            FM_SAF: begin
                if (vic_sel_i) begin
                    word_o[bit_i] = val_i;
                    // A read is compared against what was last written to the
                    // victim, not against the already-stuck stored bit.
                    hit_o = (wr_i ? new_word_i[bit_i] : ref_bit_i) != val_i;
                end
            end
            FM_TF: begin
                if (vic_sel_i && wr_i && (old_word_i[bit_i] != val_i) &&
                    (new_word_i[bit_i] == val_i)) begin
                    word_o[bit_i] = old_word_i[bit_i];
                    hit_o         = 1'b1;
                end
            end
            FM_CFID: begin
                // Rising edge of the aggressor bit forces the victim bit.
                if (aggr_sel_i && wr_i && !old_word_i[bit_i] && new_word_i[bit_i]) begin
                    vic_we_o = 1'b1;
                    hit_o    = vic_word_i[bit_i] != val_i;
                end
            end
            FM_NPSF: begin
                if (vic_sel_i && wr_i && nbr_hi_i && !nbr_lo_i) begin
                    word_o[bit_i] = old_word_i[bit_i];
                    hit_o         = new_word_i[bit_i] != old_word_i[bit_i];
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/cfg_fault_mem.sv
// -----------------------------------------------------------------------------
// cfg_fault_mem
// Single-port memory model with one runtime-configurable fault (SAF, TF,
// CFID or NPSF). Two-stage pipeline: S1 latches the command, S2 performs the
// array access through fault_mem_inject. Read latency is two cycles.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   write_read            1 = write, 0 = read
//   address, wdata        command address and write data
//   rdata                 read data (valid two cycles after the read command)
//   cfg_load              capture cfg_* this edge, effective from the next one
//   cfg_mode              fault class
//   cfg_victim, cfg_aggr  victim / aggressor word addresses
//   cfg_bit, cfg_val      fault bit index and value
//   fault_hit             one-cycle pulse when the fault altered a result
//   hit_count             saturating count of fault_hit pulses
// -----------------------------------------------------------------------------
module cfg_fault_mem
    import fault_mem_pkg::*;
#(
    parameter  int DATA_WIDTH = 8,
    parameter  int ADDR_WIDTH = 6,
    parameter  int CAPACITY   = 64,
    localparam int BIT_W      = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  write_read,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    input  logic                  cfg_load,
    input  logic [2:0]            cfg_mode,
    input  logic [ADDR_WIDTH-1:0] cfg_victim,
    input  logic [ADDR_WIDTH-1:0] cfg_aggr,
    input  logic [BIT_W-1:0]      cfg_bit,
    input  logic                  cfg_val,
    output logic                  fault_hit,
    output logic [HIT_W-1:0]      hit_count
);

    localparam int                  AW1   = ADDR_WIDTH + 1;
    localparam int                  IDX_W = (CAPACITY > 1) ? $clog2(CAPACITY) : 1;
    localparam logic [ADDR_WIDTH:0] CAP   = AW1'(CAPACITY);

    // S1 command register
    logic                  s1_wr_q;
    logic [ADDR_WIDTH-1:0] s1_addr_q;
    logic [DATA_WIDTH-1:0] s1_wdata_q;

    // Fault configuration
    logic [2:0]            mode_q;
    logic [ADDR_WIDTH-1:0] victim_q;
    logic [ADDR_WIDTH-1:0] aggr_q;
    logic [BIT_W-1:0]      bit_q;
    logic                  val_q;

    // Fault-free copy of the victim bit as last written
    logic                  shadow_q;
    logic                  shadow_vld_q;

    logic [DATA_WIDTH-1:0] rdata_q;
    logic [DATA_WIDTH-1:0] rdata_out_q;
    logic                  hit_q;
    logic [HIT_W-1:0]      hit_cnt_q;

    logic [DATA_WIDTH-1:0] int_mem [CAPACITY];

    logic                  addr_ok;
    logic                  vic_ok;
    logic                  aggr_ok;
    logic                  hi_ok;
    logic                  lo_ok;
    logic [ADDR_WIDTH:0]   vic_p1;
    logic [IDX_W-1:0]      vic_m1;
    logic [DATA_WIDTH-1:0] old_word;
    logic [DATA_WIDTH-1:0] vic_word;
    logic                  nbr_hi;
    logic                  nbr_lo;
    logic                  vic_sel;
    logic                  aggr_sel;
    logic                  ref_bit;

    logic [DATA_WIDTH-1:0] word_d;
    logic [DATA_WIDTH-1:0] vic_word_d;
    logic                  vic_we_d;
    logic                  hit_d;

    // Array-stage address qualification and neighbour fetch. Anything outside
    // 0..CAPACITY-1 reads as 0 and never matches victim or aggressor.
    always_comb begin
        addr_ok  = {1'b0, s1_addr_q} < CAP;
        vic_ok   = {1'b0, victim_q}  < CAP;
        aggr_ok  = {1'b0, aggr_q}    < CAP;
        vic_p1   = {1'b0, victim_q} + AW1'(1);
        vic_m1   = victim_q[IDX_W-1:0] - IDX_W'(1);
        hi_ok    = vic_ok && (vic_p1 < CAP);
        lo_ok    = vic_ok && (victim_q != '0);

        old_word = addr_ok ? int_mem[s1_addr_q[IDX_W-1:0]] : '0;
        vic_word = vic_ok  ? int_mem[victim_q[IDX_W-1:0]]  : '0;
        nbr_hi   = hi_ok   ? int_mem[vic_p1[IDX_W-1:0]][bit_q] : 1'b0;
        nbr_lo   = lo_ok   ? int_mem[vic_m1][bit_q]            : 1'b0;

        vic_sel  = addr_ok && (s1_addr_q == victim_q);
        // Aggressor equal to victim makes CFID inert.
        aggr_sel = addr_ok && aggr_ok && vic_ok && (s1_addr_q == aggr_q) &&
                   (aggr_q != victim_q);
        ref_bit  = shadow_vld_q ? shadow_q : old_word[bit_q];
    end

    fault_mem_inject #(
        .DATA_WIDTH (DATA_WIDTH),
        .BIT_W      (BIT_W)
    ) u_inject (
        .mode_i     (mode_q),
        .bit_i      (bit_q),
        .val_i      (val_q),
        .wr_i       (s1_wr_q),
        .vic_sel_i  (vic_sel),
        .aggr_sel_i (aggr_sel),
        .ref_bit_i  (ref_bit),
        .nbr_hi_i   (nbr_hi),
        .nbr_lo_i   (nbr_lo),
        .old_word_i (old_word),
        .new_word_i (s1_wdata_q),
        .vic_word_i (vic_word),
        .word_o     (word_d),
        .vic_we_o   (vic_we_d),
        .vic_word_o (vic_word_d),
        .hit_o      (hit_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_wr_q      <= 1'b0;
            s1_addr_q    <= '0;
            s1_wdata_q   <= '0;
            mode_q       <= FM_NONE;
            victim_q     <= '0;
            aggr_q       <= '0;
            bit_q        <= '0;
            val_q        <= 1'b0;
            shadow_q     <= 1'b0;
            shadow_vld_q <= 1'b0;
            rdata_q      <= '0;
            rdata_out_q  <= '0;
            hit_q        <= 1'b0;
            hit_cnt_q    <= '0;
        end else begin
            s1_wr_q     <= write_read;
            s1_addr_q   <= address;
            s1_wdata_q  <= wdata;

            if (!s1_wr_q) begin
                rdata_q <= word_d;
            end
            rdata_out_q <= rdata_q;

            hit_q <= hit_d;
            if (hit_d) begin
                hit_cnt_q <= sat_inc(hit_cnt_q);
            end

            if (cfg_load) begin
                mode_q       <= cfg_mode;
                victim_q     <= cfg_victim;
                aggr_q       <= cfg_aggr;
                bit_q        <= cfg_bit;
                val_q        <= cfg_val;
                // Shadow belonged to the old victim; it is meaningless now.
                shadow_vld_q <= 1'b0;
            end else if (s1_wr_q && vic_sel) begin
                shadow_q     <= s1_wdata_q[bit_q];
                shadow_vld_q <= 1'b1;
            end
        end
    end

    // Array is not reset, but a write sitting in S1 at a reset edge is dropped.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (s1_wr_q && addr_ok) begin
                int_mem[s1_addr_q[IDX_W-1:0]] <= word_d;
            end
            if (vic_we_d) begin
                int_mem[victim_q[IDX_W-1:0]] <= vic_word_d;
            end
        end
    end

    assign rdata     = rdata_out_q;
    assign fault_hit = hit_q;
    assign hit_count = hit_cnt_q;

endmodule

// File: tb/tb_cfg_fault_mem.sv
module tb_cfg_fault_mem;
    import fault_mem_pkg::*;

    localparam int DW = 8;
    localparam int AW = 7;
    localparam int CP = 64;
    localparam int BW = 3;

    logic          clk;
    logic          rst;
    logic          write_read;
    logic [AW-1:0] address;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic          cfg_load;
    logic [2:0]    cfg_mode;
    logic [AW-1:0] cfg_victim;
    logic [AW-1:0] cfg_aggr;
    logic [BW-1:0] cfg_bit;
    logic          cfg_val;
    logic          fault_hit;
    logic [15:0]   hit_count;

    cfg_fault_mem #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .CAPACITY   (CP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .write_read (write_read),
        .address    (address),
        .wdata      (wdata),
        .rdata      (rdata),
        .cfg_load   (cfg_load),
        .cfg_mode   (cfg_mode),
        .cfg_victim (cfg_victim),
        .cfg_aggr   (cfg_aggr),
        .cfg_bit    (cfg_bit),
        .cfg_val    (cfg_val),
        .fault_hit  (fault_hit),
        .hit_count  (hit_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          due;
        bit          is_hit;
        logic [7:0]  exp;
        string       tag;
    } sb_t;

    sb_t sb[$];
    int  cyc;
    int  n_cmp;
    int  n_err;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        assert (act === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
        end
    endtask

    // One clock; then compare every scoreboard entry that has come due.
    task automatic step();
        sb_t e;
        @(posedge clk);
        cyc++;
        #1;
        while (sb.size() != 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            if (e.is_hit) check(e.tag, 32'(fault_hit), 32'(e.exp[0]));
            else          check(e.tag, 32'(rdata), 32'(e.exp));
        end
    endtask

    // Issue one command. fault_hit is due after the S2 edge (2 edges on),
    // rdata after one more.
    task automatic cmd(input logic wr, input int addr, input logic [7:0] d,
                       input logic ehit, input logic [7:0] erd, input bit chk_rd,
                       input string tag);
        sb_t e;
        write_read = wr;
        address    = AW'(addr);
        wdata      = d;
        e.due = cyc + 2; e.is_hit = 1'b1; e.exp = {7'd0, ehit}; e.tag = {tag, "_hit"};
        sb.push_back(e);
        if (!wr && chk_rd) begin
            e.due = cyc + 3; e.is_hit = 1'b0; e.exp = erd; e.tag = tag;
            sb.push_back(e);
        end
        step();
        cfg_load = 1'b0;
    endtask

    task automatic idle();
        cmd(1'b0, CP, 8'h00, 1'b0, 8'h00, 1'b0, "idle");
    endtask

    task automatic arm_cfg(input logic [2:0] m, input int v, input int a,
                           input int b, input logic val);
        cfg_mode   = m;
        cfg_victim = AW'(v);
        cfg_aggr   = AW'(a);
        cfg_bit    = BW'(b);
        cfg_val    = val;
        cfg_load   = 1'b1;
    endtask

    task automatic load_cfg(input logic [2:0] m, input int v, input int a,
                            input int b, input logic val);
        arm_cfg(m, v, a, b, val);
        idle();
    endtask

    task automatic drain();
        write_read = 1'b0;
        address    = AW'(CP);
        for (int i = 0; i < 10 && sb.size() != 0; i++) step();
        check("drain", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        cyc = 0; n_cmp = 0; n_err = 0;
        rst = 1'b1; write_read = 1'b0; address = '0; wdata = '0;
        cfg_load = 1'b0; cfg_mode = FM_NONE; cfg_victim = '0; cfg_aggr = '0;
        cfg_bit = '0; cfg_val = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        check("rst_rdata", 32'(rdata), 32'd0);
        check("rst_hit", 32'(fault_hit), 32'd0);
        check("rst_count", 32'(hit_count), 32'd0);

        // No fault
        cmd(1, 3, 8'hA5, 0, 8'h00, 0, "none_w3");
        cmd(0, 3, 8'h00, 0, 8'hA5, 1, "none_r3");
        cmd(1, 0, 8'h00, 0, 8'h00, 0, "none_w0");
        drain();
        check("none_count", 32'(hit_count), 32'd0);

        // SAF: victim 5, bit 2, stuck at 0
        load_cfg(FM_SAF, 5, 0, 2, 1'b0);
        cmd(1, 5, 8'hFF, 1, 8'h00, 0, "saf_w5");
        cmd(0, 5, 8'h00, 1, 8'hFB, 1, "saf_r5");
        cmd(1, 6, 8'hFF, 0, 8'h00, 0, "saf_w6");
        cmd(0, 6, 8'h00, 0, 8'hFF, 1, "saf_r6");
        drain();
        check("saf_count", 32'(hit_count), 32'd2);

        // TF: victim 7, bit 0, 0->1 blocked
        load_cfg(FM_TF, 7, 0, 0, 1'b1);
        cmd(1, 7, 8'h00, 0, 8'h00, 0, "tf_w00");
        cmd(1, 7, 8'h01, 1, 8'h00, 0, "tf_w01");
        cmd(0, 7, 8'h00, 0, 8'h00, 1, "tf_r7");
        drain();
        check("tf_count", 32'(hit_count), 32'd3);
        // Write under NONE while TF is loaded on that same S2 edge: old config applies.
        load_cfg(FM_NONE, 0, 0, 0, 1'b0);
        cmd(1, 7, 8'h01, 0, 8'h00, 0, "tf_off_w01");
        arm_cfg(FM_TF, 7, 0, 0, 1'b1);
        cmd(0, 7, 8'h00, 0, 8'h01, 1, "tf_cfgedge_r7");
        cmd(1, 7, 8'h00, 0, 8'h00, 0, "tf_w10");
        cmd(0, 7, 8'h00, 0, 8'h00, 1, "tf_r7_fall");
        drain();

        // CFID: aggressor 10, victim 20, bit 3, forced 1
        load_cfg(FM_CFID, 20, 10, 3, 1'b1);
        cmd(1, 20, 8'h00, 0, 8'h00, 0, "cf_w20");
        cmd(1, 10, 8'h00, 0, 8'h00, 0, "cf_w10_0");
        cmd(1, 10, 8'h08, 1, 8'h00, 0, "cf_w10_8");
        cmd(0, 20, 8'h00, 0, 8'h08, 1, "cf_r20");
        cmd(0, 10, 8'h00, 0, 8'h08, 1, "cf_r10");
        cmd(1, 10, 8'h00, 0, 8'h00, 0, "cf_w10_0b");
        cmd(1, 10, 8'h08, 0, 8'h00, 0, "cf_w10_8b");
        drain();
        check("cfid_count", 32'(hit_count), 32'd4);

        // NPSF: victim 0, bit 1 (lower neighbour off the array reads 0)
        load_cfg(FM_NPSF, 0, 0, 1, 1'b0);
        cmd(1, 1, 8'h02, 0, 8'h00, 0, "np_w1_02");
        cmd(1, 0, 8'hFF, 1, 8'h00, 0, "np_w0_a");
        cmd(0, 0, 8'h00, 0, 8'hFD, 1, "np_r0_a");
        cmd(1, 1, 8'h00, 0, 8'h00, 0, "np_w1_00");
        cmd(1, 0, 8'hFF, 0, 8'h00, 0, "np_w0_b");
        cmd(0, 0, 8'h00, 0, 8'hFF, 1, "np_r0_b");
        drain();
        check("npsf_count", 32'(hit_count), 32'd5);

        // Reserved mode 5 behaves as no fault; out-of-range accesses
        load_cfg(3'd5, 4, 0, 0, 1'b0);
        cmd(1, 4, 8'h11, 0, 8'h00, 0, "m5_w4");
        cmd(0, 4, 8'h00, 0, 8'h11, 1, "m5_r4");
        cmd(1, 64, 8'h55, 0, 8'h00, 0, "oor_w64");
        cmd(0, 0, 8'h00, 0, 8'hFF, 1, "oor_r0");
        cmd(0, 64, 8'h00, 0, 8'h00, 1, "oor_r64");
        drain();
        check("m5_count", 32'(hit_count), 32'd5);

        // Reset while a write to 4 sits in S1; cfg_load during reset is ignored.
        cmd(0, 4, 8'h00, 0, 8'h00, 0, "pre_r4");
        cmd(1, 4, 8'hAA, 0, 8'h00, 0, "pre_w4");
        rst = 1'b1;
        arm_cfg(FM_SAF, 4, 0, 0, 1'b0);
        write_read = 1'b0;
        address    = AW'(CP);
        step();
        step();
        rst = 1'b0;
        cfg_load = 1'b0;
        check("mid_rst_rdata", 32'(rdata), 32'd0);
        check("mid_rst_hit", 32'(fault_hit), 32'd0);
        check("mid_rst_count", 32'(hit_count), 32'd0);
        cmd(0, 4, 8'h00, 0, 8'h11, 1, "post_rst_r4");
        drain();
        check("post_rst_count", 32'(hit_count), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
